// File: rtl/uart_pkg.sv
// uart_pkg: receiver state type and oversampling constants
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAITHI} rx_state_t;
  localparam int OVERSAMPLE = 16;
  localparam logic [3:0] SAMPLE_PT = 4'd7;
  localparam int DATA_BITS = 8;
endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchronizer for rx plus falling-edge detect on the synchronized line
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  output logic rxs,
  output logic fall
);
  logic s1, prev;
  // shift rx through two flops and keep the previous synchronized value; line idles high
  always_ff @(posedge clk)
    if (!rst) {s1, rxs, prev} <= 3'b111;
    else {s1, rxs, prev} <= {rx, s1, rxs};
  assign fall = prev & ~rxs;
endmodule

// File: rtl/uart_rx_16x.sv
// uart_rx_16x: 8-bit + parity + stop UART receiver at 16x oversampling; UART_RX_PARITY_EN enables the parity check
module uart_rx_16x #(
  parameter logic PARITYMODE = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] dataout,
  output logic       rdsig,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);
  import uart_pkg::*;
`ifdef UART_RX_PARITY_EN
  localparam logic PAR_ON = 1'b1;
`else
  localparam logic PAR_ON = 1'b0;
`endif
  rx_state_t st;
  logic rxs, fall, pbad, smp;
  logic [3:0] cnt;
  logic [2:0] idx;
  logic [7:0] shift;
  uart_rx_sync u_sync (.clk(clk), .rst(rst), .rx(rx), .rxs(rxs), .fall(fall));
  // the tick counter is cleared on the detect edge, so tick 7 is the edge where it advances 6->7; it then wraps every 16 ticks
  assign smp = cnt + 4'd1 == SAMPLE_PT;
  // frame sequencer: mid-bit sampling of start, data, parity and stop; results and rdsig registered on the stop sample
  always_ff @(posedge clk)
    if (!rst) begin
      st <= IDLE;
      cnt <= '0;
      idx <= '0;
      shift <= '0;
      pbad <= 1'b0;
      dataout <= '0;
      rdsig <= 1'b0;
      parity_err <= 1'b0;
      frame_err <= 1'b0;
      busy <= 1'b0;
    end else begin
      rdsig <= 1'b0;
      cnt <= st == IDLE ? 4'd0 : cnt + 4'd1;
      case (st)
        IDLE: if (fall) begin
          st <= START;
          busy <= 1'b1;
        end
        START: if (smp) begin
          st <= rxs ? IDLE : DATA;
          busy <= ~rxs;
          idx <= '0;
        end
        DATA: if (smp) begin
          shift <= {rxs, shift[7:1]};
          idx <= idx + 3'd1;
          if (idx == 3'(DATA_BITS - 1)) st <= PARITY;
        end
        PARITY: if (smp) begin
          pbad <= PAR_ON & (rxs ^ (^shift) ^ PARITYMODE);
          st <= STOP;
        end
        STOP: if (smp) begin
          dataout <= shift;
          parity_err <= pbad;
          frame_err <= ~rxs;
          rdsig <= 1'b1;
          st <= rxs ? IDLE : WAITHI;
          busy <= ~rxs;
        end
        WAITHI: if (rxs) begin
          st <= IDLE;
          busy <= 1'b0;
        end
        default: begin
          st <= IDLE;
          busy <= 1'b0;
        end
      endcase
    end
endmodule

// File: tb/tb_uart_rx_16x.sv
// tb_uart_rx_16x: scoreboard bench for uart_rx_16x with directed scenarios and random frames
module tb_uart_rx_16x;
  localparam logic PM = 1'b0;
`ifdef UART_RX_PARITY_EN
  localparam logic PEN = 1'b1;
`else
  localparam logic PEN = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b0, rx = 1'b1;
  logic [7:0] dataout;
  logic rdsig, parity_err, frame_err, busy;
  int total = 0, bad = 0;
  logic [9:0] q[$];
  logic [7:0] last = 8'h00;

  uart_rx_16x #(.PARITYMODE(PM)) dut (
    .clk(clk), .rst(rst), .rx(rx), .dataout(dataout), .rdsig(rdsig),
    .parity_err(parity_err), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input int a, input int e);
    total++;
    if (a != e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, a, e);
    end
  endtask

  function automatic logic par(input logic [7:0] d);
    return (^d) ^ PM;
  endfunction

  // one frame, one line tick per clock: start, 8 data LSB first, parity, stop held stop_len ticks;
  // abort >= 0 stops driving at that tick and expects no result; rx is left at its last value
  task automatic send(input logic [7:0] d, input logic p, input logic s, input int stop_len, input int abort);
    logic [10:0] bits;
    bits = {s, p, d, 1'b0};
    if (abort < 0) begin
      q.push_back({d, PEN && (p != par(d)), !s});
      last = d;
    end
    for (int t = 0; t < 160 + stop_len; t++) begin
      if (t == abort) return;
      rx = t < 160 ? bits[t / 16] : s;
      @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // monitor: every rdsig cycle must match the oldest outstanding expected frame
  always @(negedge clk)
    if (rdsig) begin : mon
      logic [9:0] e;
      chk("rdsig_has_expected_frame", q.size() != 0, 1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("dataout", dataout, e[9:2]);
        chk("parity_err", parity_err, e[1]);
        chk("frame_err", frame_err, e[0]);
      end
    end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no end of test want finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] d;
    int w;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {dataout, rdsig, parity_err, frame_err, busy}, 0);
    rst = 1'b1;
    idle(5);
    send(8'hA5, 1'b0, 1'b1, 16, -1);
    idle(4);
    send(8'h3C, 1'b1, 1'b1, 16, -1);
    idle(4);
    rx = 1'b0;
    repeat (5) @(negedge clk);
    chk("false_start_busy_high", busy, 1);
    idle(20);
    chk("false_start_busy_low", busy, 0);
    chk("dataout_held", dataout, last);
    send(8'h55, par(8'h55), 1'b0, 40, -1);
    chk("waithi_busy", busy, 1);
    idle(10);
    chk("waithi_exit_busy", busy, 0);
    send(8'h0F, par(8'h0F), 1'b1, 16, -1);
    idle(4);
    send(8'h01, par(8'h01), 1'b1, 9, -1);
    send(8'hFF, par(8'hFF), 1'b1, 9, -1);
    send(8'h80, par(8'h80), 1'b1, 9, -1);
    idle(4);
    send(8'hC3, par(8'hC3), 1'b1, 16, 80);
    rst = 1'b0;
    rx = 1'b1;
    repeat (2) @(negedge clk);
    chk("midframe_reset_outputs", {dataout, rdsig, parity_err, frame_err, busy}, 0);
    rst = 1'b1;
    idle(5);
    send(8'h5A, par(8'h5A), 1'b1, 16, -1);
    idle(4);
    for (int i = 0; i < 40; i++) begin
      d = 8'($urandom);
      send(d, $urandom_range(0, 3) == 0 ? ~par(d) : par(d), 1'b1, $urandom_range(8, 20), -1);
      idle($urandom_range(1, 6));
    end
    w = 0;
    while (q.size() != 0 && w < 500) begin
      @(negedge clk);
      w++;
    end
    chk("all_frames_received", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
